// File: rtl/key_entry_pkg.sv
// ============================================================================
// key_entry_pkg : key codes and FSM state type shared by the key_entry block
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package key_entry_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_entry_timer.sv
// ============================================================================
// key_timer : loadable down-counter shared by the OPEN and LOCKOUT states
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module key_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    // Flags the edge on which the count reaches zero, so a load of N
    // keeps the owning state alive for exactly N cycles.
    assign o_zero = (r_cnt == W'(1));

endmodule

`default_nettype wire

// File: rtl/key_entry.sv
// ============================================================================
// key_entry : keypad entry buffer, password check, failed-attempt lockout
//             and open-state inactivity timeout
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module key_entry
    import key_entry_pkg::*;
#(
    parameter int MAX_FAIL     = 3,
    parameter int LOCK_CYCLES  = 1000,
    parameter int OPEN_TIMEOUT = 5000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    input  logic [15:0]                   pw,
    input  logic [15:0]                   pw_temp,
    input  logic                          pw_temp_valid,
    output logic [15:0]                   display,
    output logic [2:0]                    digit_cnt,
    output logic                          star,
    output logic                          hash,
    output logic                          correct,
    output logic                          pw_temp_reset,
    output logic                          locked,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int TMAX = (LOCK_CYCLES > OPEN_TIMEOUT) ? LOCK_CYCLES : OPEN_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [15:0]    r_display;
    logic [15:0]    w_display_nxt;
    logic [2:0]     r_digit_cnt;
    logic [2:0]     w_digit_cnt_nxt;
    logic [FW-1:0]  r_fail_cnt;
    logic [FW-1:0]  w_fail_cnt_nxt;
    logic [FW-1:0]  w_fail_inc;
    logic           r_star;
    logic           w_star_nxt;
    logic           r_hash;
    logic           w_hash_nxt;
    logic           r_ptr;
    logic           w_ptr_nxt;
    logic           w_tmr_load;
    logic [TW-1:0]  w_tmr_val;
    logic           w_tmr_zero;

    logic w_key_digit;
    logic w_key_star;
    logic w_key_hash;
    logic w_key_clr;
    logic w_hit_p;
    logic w_hit_t;

    assign w_key_digit = key_valid && is_digit(key_code);
    assign w_key_star  = key_valid && (key_code == KEY_STAR);
    assign w_key_hash  = key_valid && (key_code == KEY_HASH);
    assign w_key_clr   = key_valid && (key_code == KEY_CLR);
    assign w_hit_p     = (r_display == pw);
    assign w_hit_t     = pw_temp_valid && (r_display == pw_temp);
    assign w_fail_inc  = r_fail_cnt + FW'(1);

    key_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_display   <= '0;
            r_digit_cnt <= '0;
            r_fail_cnt  <= '0;
            r_star      <= 1'b0;
            r_hash      <= 1'b0;
            r_ptr       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_display   <= w_display_nxt;
            r_digit_cnt <= w_digit_cnt_nxt;
            r_fail_cnt  <= w_fail_cnt_nxt;
            r_star      <= w_star_nxt;
            r_hash      <= w_hash_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_display_nxt   = r_display;
        w_digit_cnt_nxt = r_digit_cnt;
        w_fail_cnt_nxt  = r_fail_cnt;
        w_star_nxt      = 1'b0;
        w_hash_nxt      = 1'b0;
        w_ptr_nxt       = 1'b0;
        w_tmr_load      = 1'b0;
        w_tmr_val       = TW'(OPEN_TIMEOUT);

        case (r_state)
            IDLE, ENTRY, OPEN: begin
                if (w_key_digit) begin
                    w_display_nxt   = {r_display[11:0], key_code};
                    w_digit_cnt_nxt = (r_digit_cnt == 3'd4) ? 3'd4 : r_digit_cnt + 3'd1;
                    if (r_state == IDLE) begin
                        w_state_nxt = (r_digit_cnt == 3'd3) ? CHECK : ENTRY;
                    end else if (r_state == ENTRY && r_digit_cnt == 3'd3) begin
                        w_state_nxt = CHECK;
                    end
                end else if (w_key_star) begin
                    w_star_nxt = 1'b1;
                end else if (w_key_hash) begin
                    w_hash_nxt = 1'b1;
                end else if (w_key_clr) begin
                    w_display_nxt   = '0;
                    w_digit_cnt_nxt = '0;
                    w_state_nxt     = IDLE;
                end

                // Any accepted key keeps the door open; otherwise let it time out.
                if (r_state == OPEN && !w_key_clr) begin
                    if (w_key_digit || w_key_star || w_key_hash) begin
                        w_tmr_load = 1'b1;
                    end else if (w_tmr_zero) begin
                        w_state_nxt     = IDLE;
                        w_display_nxt   = '0;
                        w_digit_cnt_nxt = '0;
                    end
                end
            end

            CHECK: begin
                w_display_nxt   = '0;
                w_digit_cnt_nxt = '0;
                w_tmr_load      = 1'b1;
                if (w_hit_p || w_hit_t) begin
                    w_state_nxt    = OPEN;
                    w_fail_cnt_nxt = '0;
                    w_ptr_nxt      = w_hit_t && !w_hit_p;
                end else begin
                    w_fail_cnt_nxt = w_fail_inc;
                    if (w_fail_inc == FW'(MAX_FAIL)) begin
                        w_state_nxt = LOCKOUT;
                        w_tmr_val   = TW'(LOCK_CYCLES);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            LOCKOUT: begin
                if (w_tmr_zero) begin
                    w_state_nxt    = IDLE;
                    w_fail_cnt_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign display       = r_display;
    assign digit_cnt     = r_digit_cnt;
    assign star          = r_star;
    assign hash          = r_hash;
    assign pw_temp_reset = r_ptr;
    assign fail_cnt      = r_fail_cnt;
    assign correct       = (r_state == OPEN);
    assign locked        = (r_state == LOCKOUT);

endmodule

`default_nettype wire
